// File: rtl/hazard_ctrl_unit.sv
// Hazard controller for the 5-stage pipeline.
// Handles:
//   - load-use stalls
//   - branch hold-until-resolve
//   - multi-cycle IF/ID flush on a taken branch
//   - EX operand forwarding selects
//   - saturating stall/flush performance counters
// Stall and flush are Mealy outputs of a small FSM. They are forced low,
// together with the forwarding selects, while reset is asserted.
module hazard_ctrl_unit #(
    parameter int unsigned REG_AW     = 5,
    parameter int unsigned LOAD_STALL = 1,
    parameter int unsigned FLUSH_CYC  = 1,
    parameter int unsigned CNT_W      = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [REG_AW-1:0] i_rs1_id,
    input  logic [REG_AW-1:0] i_rs2_id,
    input  logic [REG_AW-1:0] i_rs1_ex,
    input  logic [REG_AW-1:0] i_rs2_ex,
    input  logic [REG_AW-1:0] i_rd_ex,
    input  logic [REG_AW-1:0] i_rd_mem,
    input  logic [REG_AW-1:0] i_rd_wb,
    input  logic              i_mem_read_ex,
    input  logic              i_reg_write_mem,
    input  logic              i_reg_write_wb,
    input  logic              i_branch_id,
    input  logic              i_branch_resolved,
    input  logic              i_branch_taken,
    input  logic              i_clr_cnt,
    output logic              o_stall,
    output logic              o_flush,
    output logic [1:0]        o_forward_a,
    output logic [1:0]        o_forward_b,
    output logic [CNT_W-1:0]  o_stall_cnt,
    output logic [CNT_W-1:0]  o_flush_cnt
);

    typedef enum logic [1:0] {
        StIdle,
        StLoadStall,
        StBrWait,
        StFlush
    } state_e;

    // The first stall/flush cycle is issued from IDLE, so the counter is
    // loaded with the number of cycles still to go after that one.
    localparam logic [3:0] LoadRem  = 4'(LOAD_STALL - 1);
    localparam logic [3:0] FlushRem = 4'(FLUSH_CYC - 1);

    localparam logic [1:0] FwdRegfile = 2'b00;
    localparam logic [1:0] FwdExMem   = 2'b10;
    localparam logic [1:0] FwdMemWb   = 2'b01;

    localparam logic [CNT_W-1:0] CntMax = '1;
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [3:0]       r_rem;
    logic [3:0]       w_rem_nxt;
    logic             w_stall_fsm;
    logic             w_flush_fsm;
    logic             w_load_haz;
    logic             w_br_taken;
    logic [1:0]       w_fwd_a;
    logic [1:0]       w_fwd_b;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    // Load-use hazard detection: x0 is never a real destination.
    always_comb begin
        w_load_haz = i_mem_read_ex && (i_rd_ex != '0) &&
                     ((i_rs1_id == i_rd_ex) || (i_rs2_id == i_rd_ex));
        w_br_taken = i_branch_resolved && i_branch_taken;
    end

    // State and remaining-cycle register.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= StIdle;
            r_rem   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_rem   <= w_rem_nxt;
        end
    end

    // Next-state and Mealy stall/flush decode.
    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem;
        w_stall_fsm = 1'b0;
        w_flush_fsm = 1'b0;
        case (r_state)
            StIdle: begin
                if (w_load_haz) begin
                    w_stall_fsm = 1'b1;
                    if (LOAD_STALL > 1) begin
                        w_state_nxt = StLoadStall;
                        w_rem_nxt   = LoadRem;
                    end
                end else if (i_branch_id) begin
                    w_stall_fsm = 1'b1;
                    w_state_nxt = StBrWait;
                end else if (w_br_taken) begin
                    w_flush_fsm = 1'b1;
                    if (FLUSH_CYC > 1) begin
                        w_state_nxt = StFlush;
                        w_rem_nxt   = FlushRem;
                    end
                end
            end
            StLoadStall: begin
                w_stall_fsm = 1'b1;
                if (r_rem <= 4'd1) begin
                    w_state_nxt = StIdle;
                    w_rem_nxt   = '0;
                end else begin
                    w_rem_nxt = r_rem - 4'd1;
                end
            end
            StBrWait: begin
                // Hold the front end until the outcome arrives; load hazards
                // cannot occur behind a frozen ID stage.
                if (i_branch_resolved) begin
                    if (i_branch_taken) begin
                        w_flush_fsm = 1'b1;
                        if (FLUSH_CYC > 1) begin
                            w_state_nxt = StFlush;
                            w_rem_nxt   = FlushRem;
                        end else begin
                            w_state_nxt = StIdle;
                        end
                    end else begin
                        w_state_nxt = StIdle;
                    end
                end else begin
                    w_stall_fsm = 1'b1;
                end
            end
            StFlush: begin
                w_flush_fsm = 1'b1;
                if (r_rem <= 4'd1) begin
                    w_state_nxt = StIdle;
                    w_rem_nxt   = '0;
                end else begin
                    w_rem_nxt = r_rem - 4'd1;
                end
            end
            default: begin
                w_state_nxt = StIdle;
                w_rem_nxt   = '0;
            end
        endcase
    end

    // Forwarding selects: the younger MEM result wins over WB.
    always_comb begin
        w_fwd_a = FwdRegfile;
        w_fwd_b = FwdRegfile;
        if (i_reg_write_mem && (i_rd_mem != '0) && (i_rd_mem == i_rs1_ex)) begin
            w_fwd_a = FwdExMem;
        end else if (i_reg_write_wb && (i_rd_wb != '0) && (i_rd_wb == i_rs1_ex)) begin
            w_fwd_a = FwdMemWb;
        end
        if (i_reg_write_mem && (i_rd_mem != '0) && (i_rd_mem == i_rs2_ex)) begin
            w_fwd_b = FwdExMem;
        end else if (i_reg_write_wb && (i_rd_wb != '0) && (i_rd_wb == i_rs2_ex)) begin
            w_fwd_b = FwdMemWb;
        end
    end

    // Outputs are gated by reset so nothing leaks while reset is held.
    always_comb begin
        o_stall     = i_reset & w_stall_fsm;
        o_flush     = i_reset & w_flush_fsm;
        o_forward_a = i_reset ? w_fwd_a : FwdRegfile;
        o_forward_b = i_reset ? w_fwd_b : FwdRegfile;
        o_stall_cnt = r_stall_cnt;
        o_flush_cnt = r_flush_cnt;
    end

    // Saturating performance counters; a clear beats an increment.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (i_clr_cnt) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_fsm && (r_stall_cnt != CntMax)) begin
                r_stall_cnt <= r_stall_cnt + CntOne;
            end
            if (w_flush_fsm && (r_flush_cnt != CntMax)) begin
                r_flush_cnt <= r_flush_cnt + CntOne;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Scoreboard bench for hazard_ctrl_unit.
// Two instances run side by side on shared stimulus:
//   - inst 0: LOAD_STALL=3, FLUSH_CYC=2, 16-bit counters
//   - inst 1: LOAD_STALL=1, FLUSH_CYC=1, 3-bit counters (reaches saturation)
// The driver computes expectations from a cycle-debt model and queues them.
// The monitor pops one entry per cycle and compares it with the DUT outputs.
module tb_hazard_ctrl_unit;

    localparam int LS0 = 3;
    localparam int FC0 = 2;
    localparam int CW0 = 16;
    localparam int LS1 = 1;
    localparam int FC1 = 1;
    localparam int CW1 = 3;

    typedef struct packed {
        logic [4:0] rs1_id;
        logic [4:0] rs2_id;
        logic [4:0] rs1_ex;
        logic [4:0] rs2_ex;
        logic [4:0] rd_ex;
        logic [4:0] rd_mem;
        logic [4:0] rd_wb;
        logic       mem_read_ex;
        logic       reg_write_mem;
        logic       reg_write_wb;
        logic       branch_id;
        logic       branch_resolved;
        logic       branch_taken;
        logic       clr_cnt;
    } stim_t;

    typedef struct {
        int stall0;
        int flush0;
        int stall1;
        int flush1;
        int fa;
        int fb;
        int scnt0;
        int fcnt0;
        int scnt1;
        int fcnt1;
    } exp_t;

    logic clk;
    logic rst_n;
    stim_t s_cur;

    logic           stall0, flush0, stall1, flush1;
    logic [1:0]     fa0, fb0, fa1, fb1;
    logic [CW0-1:0] scnt0, fcnt0;
    logic [CW1-1:0] scnt1, fcnt1;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Model: cycles of stall/flush still owed, and whether a branch is pending.
    int load_left[2];
    int flush_left[2];
    int in_br[2];
    int m_scnt[2];
    int m_fcnt[2];

    hazard_ctrl_unit #(.REG_AW(5), .LOAD_STALL(LS0), .FLUSH_CYC(FC0), .CNT_W(CW0)) u_dut0 (
        .i_clk(clk), .i_reset(rst_n),
        .i_rs1_id(s_cur.rs1_id), .i_rs2_id(s_cur.rs2_id),
        .i_rs1_ex(s_cur.rs1_ex), .i_rs2_ex(s_cur.rs2_ex),
        .i_rd_ex(s_cur.rd_ex), .i_rd_mem(s_cur.rd_mem), .i_rd_wb(s_cur.rd_wb),
        .i_mem_read_ex(s_cur.mem_read_ex), .i_reg_write_mem(s_cur.reg_write_mem),
        .i_reg_write_wb(s_cur.reg_write_wb), .i_branch_id(s_cur.branch_id),
        .i_branch_resolved(s_cur.branch_resolved), .i_branch_taken(s_cur.branch_taken),
        .i_clr_cnt(s_cur.clr_cnt),
        .o_stall(stall0), .o_flush(flush0), .o_forward_a(fa0), .o_forward_b(fb0),
        .o_stall_cnt(scnt0), .o_flush_cnt(fcnt0)
    );

    hazard_ctrl_unit #(.REG_AW(5), .LOAD_STALL(LS1), .FLUSH_CYC(FC1), .CNT_W(CW1)) u_dut1 (
        .i_clk(clk), .i_reset(rst_n),
        .i_rs1_id(s_cur.rs1_id), .i_rs2_id(s_cur.rs2_id),
        .i_rs1_ex(s_cur.rs1_ex), .i_rs2_ex(s_cur.rs2_ex),
        .i_rd_ex(s_cur.rd_ex), .i_rd_mem(s_cur.rd_mem), .i_rd_wb(s_cur.rd_wb),
        .i_mem_read_ex(s_cur.mem_read_ex), .i_reg_write_mem(s_cur.reg_write_mem),
        .i_reg_write_wb(s_cur.reg_write_wb), .i_branch_id(s_cur.branch_id),
        .i_branch_resolved(s_cur.branch_resolved), .i_branch_taken(s_cur.branch_taken),
        .i_clr_cnt(s_cur.clr_cnt),
        .o_stall(stall1), .o_flush(flush1), .o_forward_a(fa1), .o_forward_b(fb1),
        .o_stall_cnt(scnt1), .o_flush_cnt(fcnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int fwd(input logic [4:0] rs, input stim_t s);
        if (s.reg_write_mem && s.rd_mem != 0 && s.rd_mem == rs) return 2;
        if (s.reg_write_wb && s.rd_wb != 0 && s.rd_wb == rs) return 1;
        return 0;
    endfunction

    function automatic stim_t idle_stim();
        stim_t s;
        s = '0;
        return s;
    endfunction

    // One cycle of the reference behaviour for instance d.
    task automatic model_step(input int d, input stim_t s, output int st, output int fl);
        int ls;
        int fc;
        bit haz;
        ls  = (d == 0) ? LS0 : LS1;
        fc  = (d == 0) ? FC0 : FC1;
        haz = s.mem_read_ex && s.rd_ex != 0 && (s.rs1_id == s.rd_ex || s.rs2_id == s.rd_ex);
        st  = 0;
        fl  = 0;
        if (load_left[d] > 0) begin
            st = 1;
            load_left[d]--;
        end else if (flush_left[d] > 0) begin
            fl = 1;
            flush_left[d]--;
        end else if (in_br[d] != 0) begin
            if (s.branch_resolved) begin
                in_br[d] = 0;
                if (s.branch_taken) begin
                    fl = 1;
                    flush_left[d] = fc - 1;
                end
            end else begin
                st = 1;
            end
        end else if (haz) begin
            st = 1;
            load_left[d] = ls - 1;
        end else if (s.branch_id) begin
            st = 1;
            in_br[d] = 1;
        end else if (s.branch_resolved && s.branch_taken) begin
            fl = 1;
            flush_left[d] = fc - 1;
        end
        if (s.clr_cnt) begin
            m_scnt[d] = 0;
            m_fcnt[d] = 0;
        end else begin
            if (st != 0 && m_scnt[d] < (1 << ((d == 0) ? CW0 : CW1)) - 1) m_scnt[d]++;
            if (fl != 0 && m_fcnt[d] < (1 << ((d == 0) ? CW0 : CW1)) - 1) m_fcnt[d]++;
        end
    endtask

    // Apply one cycle of stimulus and queue the response it should produce.
    task automatic drive(input stim_t s, input logic rn);
        exp_t e;
        int st;
        int fl;
        @(posedge clk);
        #1;
        s_cur = s;
        rst_n = rn;
        e.scnt0 = m_scnt[0];
        e.fcnt0 = m_fcnt[0];
        e.scnt1 = m_scnt[1];
        e.fcnt1 = m_fcnt[1];
        if (!rn) begin
            for (int d = 0; d < 2; d++) begin
                load_left[d]  = 0;
                flush_left[d] = 0;
                in_br[d]      = 0;
                m_scnt[d]     = 0;
                m_fcnt[d]     = 0;
            end
            e = '{default: 0};
        end else begin
            model_step(0, s, st, fl);
            e.stall0 = st;
            e.flush0 = fl;
            model_step(1, s, st, fl);
            e.stall1 = st;
            e.flush1 = fl;
            e.fa = fwd(s.rs1_ex, s);
            e.fb = fwd(s.rs2_ex, s);
        end
        q.push_back(e);
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: outputs are valid every cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check("stall0", int'(stall0), e.stall0);
            check("flush0", int'(flush0), e.flush0);
            check("stall1", int'(stall1), e.stall1);
            check("flush1", int'(flush1), e.flush1);
            check("overlap0", int'(stall0 & flush0), 0);
            check("fwd_a0", int'(fa0), e.fa);
            check("fwd_b0", int'(fb0), e.fb);
            check("fwd_a1", int'(fa1), e.fa);
            check("fwd_b1", int'(fb1), e.fb);
            check("stall_cnt0", int'(scnt0), e.scnt0);
            check("flush_cnt0", int'(fcnt0), e.fcnt0);
            check("stall_cnt1", int'(scnt1), e.scnt1);
            check("flush_cnt1", int'(fcnt1), e.fcnt1);
        end
    end

    initial begin
        stim_t s;
        s_cur = idle_stim();
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            load_left[d]  = 0;
            flush_left[d] = 0;
            in_br[d]      = 0;
            m_scnt[d]     = 0;
            m_fcnt[d]     = 0;
        end

        drive(idle_stim(), 1'b0);
        drive(idle_stim(), 1'b0);
        drive(idle_stim(), 1'b1);

        // Load-use hazard on rs2 for one cycle.
        s = idle_stim();
        s.mem_read_ex = 1'b1;
        s.rd_ex = 5'd5;
        s.rs2_id = 5'd5;
        drive(s, 1'b1);
        repeat (4) drive(idle_stim(), 1'b1);

        // x0 never hazards or forwards.
        s = idle_stim();
        s.mem_read_ex = 1'b1;
        s.reg_write_mem = 1'b1;
        drive(s, 1'b1);

        // Branch held two extra cycles, then resolved taken.
        s = idle_stim();
        s.branch_id = 1'b1;
        drive(s, 1'b1);
        repeat (2) drive(idle_stim(), 1'b1);
        s = idle_stim();
        s.branch_resolved = 1'b1;
        s.branch_taken = 1'b1;
        drive(s, 1'b1);
        repeat (3) drive(idle_stim(), 1'b1);

        // Forwarding priority: MEM over WB, then WB alone.
        s = idle_stim();
        s.rd_mem = 5'd7;
        s.rd_wb = 5'd7;
        s.reg_write_mem = 1'b1;
        s.reg_write_wb = 1'b1;
        s.rs1_ex = 5'd7;
        s.rs2_ex = 5'd7;
        drive(s, 1'b1);
        s.reg_write_mem = 1'b0;
        drive(s, 1'b1);

        // Counter clear, then reset in the middle of a load stall.
        s = idle_stim();
        s.clr_cnt = 1'b1;
        drive(s, 1'b1);
        s = idle_stim();
        s.mem_read_ex = 1'b1;
        s.rd_ex = 5'd3;
        s.rs1_id = 5'd3;
        drive(s, 1'b1);
        drive(idle_stim(), 1'b0);
        repeat (3) drive(idle_stim(), 1'b1);

        // Random traffic with small register indices so matches are common.
        for (int i = 0; i < 3000; i++) begin
            s.rs1_id          = 5'($urandom_range(0, 7));
            s.rs2_id          = 5'($urandom_range(0, 7));
            s.rs1_ex          = 5'($urandom_range(0, 7));
            s.rs2_ex          = 5'($urandom_range(0, 7));
            s.rd_ex           = 5'($urandom_range(0, 7));
            s.rd_mem          = 5'($urandom_range(0, 7));
            s.rd_wb           = 5'($urandom_range(0, 7));
            s.mem_read_ex     = ($urandom_range(0, 9) < 3);
            s.reg_write_mem   = ($urandom_range(0, 9) < 6);
            s.reg_write_wb    = ($urandom_range(0, 9) < 6);
            s.branch_id       = ($urandom_range(0, 19) < 3);
            s.branch_resolved = ($urandom_range(0, 9) < 3);
            s.branch_taken    = $urandom_range(0, 1) == 1;
            s.clr_cnt         = ($urandom_range(0, 79) == 0);
            drive(s, ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1);
        end
        drive(idle_stim(), 1'b1);

        // Let the monitor drain the queue, bounded.
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        check("queue_drain", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
